// File: rtl/cache_axi_arbiter.sv
// Shares one AXI3 master between the icache (read-only, s0) and dcache (read/write, s1) engines.
// Define ARB_RR_EN for round-robin read arbitration; otherwise s1 has fixed priority over s0.
module cache_axi_arbiter #(
    parameter int ID_W      = 4,
    parameter int WPEND_MAX = 3
) (
    input  logic            aclk,
    input  logic            aresetn,
    // icache read port
    input  logic [31:0]     s0_araddr,
    input  logic [3:0]      s0_arlen,
    input  logic [2:0]      s0_arsize,
    input  logic            s0_arvalid,
    output logic            s0_arready,
    output logic [31:0]     s0_rdata,
    output logic            s0_rlast,
    output logic            s0_rvalid,
    input  logic            s0_rready,
    // dcache read port
    input  logic [31:0]     s1_araddr,
    input  logic [3:0]      s1_arlen,
    input  logic [2:0]      s1_arsize,
    input  logic            s1_arvalid,
    output logic            s1_arready,
    output logic [31:0]     s1_rdata,
    output logic            s1_rlast,
    output logic            s1_rvalid,
    input  logic            s1_rready,
    // dcache write port
    input  logic [31:0]     s1_awaddr,
    input  logic [3:0]      s1_awlen,
    input  logic [2:0]      s1_awsize,
    input  logic [1:0]      s1_awburst,
    input  logic [1:0]      s1_awlock,
    input  logic [3:0]      s1_awcache,
    input  logic [2:0]      s1_awprot,
    input  logic            s1_awvalid,
    output logic            s1_awready,
    input  logic [31:0]     s1_wdata,
    input  logic [3:0]      s1_wstrb,
    input  logic            s1_wlast,
    input  logic            s1_wvalid,
    output logic            s1_wready,
    output logic            s1_bvalid,
    output logic [1:0]      s1_bresp,
    input  logic            s1_bready,
    // master port
    output logic [ID_W-1:0] m_arid,
    output logic [31:0]     m_araddr,
    output logic [3:0]      m_arlen,
    output logic [2:0]      m_arsize,
    output logic [1:0]      m_arburst,
    output logic [1:0]      m_arlock,
    output logic [3:0]      m_arcache,
    output logic [2:0]      m_arprot,
    output logic            m_arvalid,
    input  logic            m_arready,
    input  logic [31:0]     m_rdata,
    input  logic [ID_W-1:0] m_rid,
    input  logic [1:0]      m_rresp,
    input  logic            m_rlast,
    input  logic            m_rvalid,
    output logic            m_rready,
    output logic [ID_W-1:0] m_awid,
    output logic [31:0]     m_awaddr,
    output logic [3:0]      m_awlen,
    output logic [2:0]      m_awsize,
    output logic [1:0]      m_awburst,
    output logic [1:0]      m_awlock,
    output logic [3:0]      m_awcache,
    output logic [2:0]      m_awprot,
    output logic            m_awvalid,
    input  logic            m_awready,
    output logic [ID_W-1:0] m_wid,
    output logic [31:0]     m_wdata,
    output logic [3:0]      m_wstrb,
    output logic            m_wlast,
    output logic            m_wvalid,
    input  logic            m_wready,
    input  logic [ID_W-1:0] m_bid,
    input  logic [1:0]      m_bresp,
    input  logic            m_bvalid,
    output logic            m_bready
);

    localparam int WP_W = $clog2(WPEND_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_AR, S_R} state_e;

    state_e            state_q, state_d;
    logic              gnt_q, gnt_d;
    logic [WP_W-1:0]   wpend_q, wpend_d;
    logic              wpend_room;
    logic              elig0, elig1;
    logic              aw_hs, b_hs;
    logic              unused_resp;

`ifdef ARB_RR_EN
    logic              rr_q, rr_d;
`endif

    // Routing relies on gnt alone; the returned IDs and responses carry no routing information.
    assign unused_resp = ^{m_rid, m_rresp, m_bid};

    // Write channels: straight pass-through from s1, gated only by the outstanding-write limit.
    assign wpend_room = (wpend_q < WP_W'(WPEND_MAX));
    assign m_awid     = {{(ID_W-1){1'b0}}, 1'b1};
    assign m_awaddr   = s1_awaddr;
    assign m_awlen    = s1_awlen;
    assign m_awsize   = s1_awsize;
    assign m_awburst  = s1_awburst;
    assign m_awlock   = s1_awlock;
    assign m_awcache  = s1_awcache;
    assign m_awprot   = s1_awprot;
    assign m_awvalid  = s1_awvalid & wpend_room;
    assign s1_awready = m_awready & wpend_room;
    assign m_wid      = {{(ID_W-1){1'b0}}, 1'b1};
    assign m_wdata    = s1_wdata;
    assign m_wstrb    = s1_wstrb;
    assign m_wlast    = s1_wlast;
    assign m_wvalid   = s1_wvalid;
    assign s1_wready  = m_wready;
    assign s1_bvalid  = m_bvalid;
    assign s1_bresp   = m_bresp;
    assign m_bready   = s1_bready;

    assign aw_hs = m_awvalid & m_awready;
    assign b_hs  = m_bvalid & s1_bready;

    always_comb begin
        wpend_d = wpend_q;
        if (aw_hs && !b_hs) begin
            wpend_d = wpend_q + WP_W'(1);
        end else if (b_hs && !aw_hs) begin
            wpend_d = wpend_q - WP_W'(1);
        end
    end

    // Read address fields follow the current grant; only arvalid is qualified by state.
    assign m_arid    = {{(ID_W-1){1'b0}}, gnt_q};
    assign m_araddr  = gnt_q ? s1_araddr : s0_araddr;
    assign m_arlen   = gnt_q ? s1_arlen  : s0_arlen;
    assign m_arsize  = gnt_q ? s1_arsize : s0_arsize;
    assign m_arburst = 2'b01;
    assign m_arlock  = 2'b00;
    assign m_arcache = 4'b0000;
    assign m_arprot  = 3'b000;
    assign s0_rdata  = m_rdata;
    assign s0_rlast  = m_rlast;
    assign s1_rdata  = m_rdata;
    assign s1_rlast  = m_rlast;

    // A dcache read must not overtake any write still in flight or being presented.
    assign elig0 = s0_arvalid;
    assign elig1 = s1_arvalid && (wpend_q == '0) && !m_awvalid;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
`ifdef ARB_RR_EN
        rr_d       = rr_q;
`endif
        m_arvalid  = 1'b0;
        s0_arready = 1'b0;
        s1_arready = 1'b0;
        m_rready   = 1'b0;
        s0_rvalid  = 1'b0;
        s1_rvalid  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (elig0 || elig1) begin
                    state_d = S_AR;
`ifdef ARB_RR_EN
                    gnt_d = (elig0 && elig1) ? ~rr_q : elig1;
                    rr_d  = gnt_d;
`else
                    gnt_d = elig1;
`endif
                end
            end
            S_AR: begin
                m_arvalid  = gnt_q ? s1_arvalid : s0_arvalid;
                s0_arready = !gnt_q && m_arready;
                s1_arready = gnt_q && m_arready;
                if (m_arvalid && m_arready) begin
                    state_d = S_R;
                end
            end
            S_R: begin
                m_rready  = gnt_q ? s1_rready : s0_rready;
                s0_rvalid = !gnt_q && m_rvalid;
                s1_rvalid = gnt_q && m_rvalid;
                if (m_rvalid && m_rready && m_rlast) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= S_IDLE;
            gnt_q   <= 1'b0;
            wpend_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            wpend_q <= wpend_d;
        end
    end

`ifdef ARB_RR_EN
    // Remembers the last grant; reset as if s0 had been served last.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Directed bench for cache_axi_arbiter: read routing, arbitration order, write hold-off,
// wpend saturation and asynchronous reset mid-burst.
module tb_cache_axi_arbiter;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] s0_araddr, s1_araddr, s0_rdata, s1_rdata;
    logic [3:0]  s0_arlen, s1_arlen;
    logic [2:0]  s0_arsize, s1_arsize;
    logic        s0_arvalid, s0_arready, s0_rlast, s0_rvalid, s0_rready;
    logic        s1_arvalid, s1_arready, s1_rlast, s1_rvalid, s1_rready;
    logic [31:0] s1_awaddr, s1_wdata;
    logic [3:0]  s1_awlen, s1_awcache, s1_wstrb;
    logic [2:0]  s1_awsize, s1_awprot;
    logic [1:0]  s1_awburst, s1_awlock, s1_bresp;
    logic        s1_awvalid, s1_awready, s1_wlast, s1_wvalid, s1_wready;
    logic        s1_bvalid, s1_bready;
    logic [3:0]  m_arid, m_rid, m_awid, m_wid, m_bid;
    logic [31:0] m_araddr, m_rdata, m_awaddr, m_wdata;
    logic [3:0]  m_arlen, m_arcache, m_awlen, m_awcache, m_wstrb;
    logic [2:0]  m_arsize, m_arprot, m_awsize, m_awprot;
    logic [1:0]  m_arburst, m_arlock, m_rresp, m_awburst, m_awlock, m_bresp;
    logic        m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
    logic        m_awvalid, m_awready, m_wlast, m_wvalid, m_wready;
    logic        m_bvalid, m_bready;

    int n_cmp = 0;
    int n_bad = 0;

    cache_axi_arbiter #(.ID_W(4), .WPEND_MAX(3)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arsize(s0_arsize),
        .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
        .s0_rdata(s0_rdata), .s0_rlast(s0_rlast), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
        .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arsize(s1_arsize),
        .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
        .s1_rdata(s1_rdata), .s1_rlast(s1_rlast), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
        .s1_awaddr(s1_awaddr), .s1_awlen(s1_awlen), .s1_awsize(s1_awsize),
        .s1_awburst(s1_awburst), .s1_awlock(s1_awlock), .s1_awcache(s1_awcache),
        .s1_awprot(s1_awprot), .s1_awvalid(s1_awvalid), .s1_awready(s1_awready),
        .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wlast(s1_wlast),
        .s1_wvalid(s1_wvalid), .s1_wready(s1_wready),
        .s1_bvalid(s1_bvalid), .s1_bresp(s1_bresp), .s1_bready(s1_bready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache),
        .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rid(m_rid), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_awburst(m_awburst), .m_awlock(m_awlock), .m_awcache(m_awcache),
        .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wid(m_wid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called in the AR cycle: completes the address handshake and returns `beats` beats.
    task automatic serve(input logic who, input int beats);
        chk("ar_valid", 32'(m_arvalid), 32'd1);
        chk("ar_id", 32'(m_arid), 32'(who));
        chk("ar_burst", 32'(m_arburst), 32'd1);
        m_arready = 1'b1;
        #1;
        chk("arready_gnt", 32'(who ? s1_arready : s0_arready), 32'd1);
        chk("arready_other", 32'(who ? s0_arready : s1_arready), 32'd0);
        tick();
        m_arready = 1'b0;
        if (who) s1_arvalid = 1'b0;
        else     s0_arvalid = 1'b0;
        for (int i = 0; i < beats; i++) begin
            m_rvalid = 1'b1;
            m_rdata  = 32'hD000_0000 + (32'(who) << 16) + 32'(i);
            m_rlast  = (i == beats - 1);
            #1;
            chk("rvalid_gnt", 32'(who ? s1_rvalid : s0_rvalid), 32'd1);
            chk("rvalid_other", 32'(who ? s0_rvalid : s1_rvalid), 32'd0);
            chk("rdata_gnt", who ? s1_rdata : s0_rdata, 32'hD000_0000 + (32'(who) << 16) + 32'(i));
            chk("m_rready", 32'(m_rready), 32'd1);
            $display("beat gnt=%0d idx=%0d rdata=%h", who, i, m_rdata);
            tick();
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        $display("read burst gnt=%0d beats=%0d done", who, beats);
    endtask

    logic exp_gnt [3];

    initial begin
`ifdef ARB_RR_EN
        exp_gnt = '{1'b1, 1'b0, 1'b1};
`else
        exp_gnt = '{1'b1, 1'b1, 1'b1};
`endif
        aresetn = 1'b0;
        s0_araddr = '0; s0_arlen = '0; s0_arsize = 3'd2; s0_arvalid = 1'b0; s0_rready = 1'b1;
        s1_araddr = '0; s1_arlen = '0; s1_arsize = 3'd2; s1_arvalid = 1'b0; s1_rready = 1'b1;
        s1_awaddr = '0; s1_awlen = '0; s1_awsize = 3'd2; s1_awburst = 2'b01; s1_awlock = '0;
        s1_awcache = '0; s1_awprot = '0; s1_awvalid = 1'b0;
        s1_wdata = '0; s1_wstrb = 4'hF; s1_wlast = 1'b0; s1_wvalid = 1'b0; s1_bready = 1'b1;
        m_arready = 1'b0; m_rdata = '0; m_rid = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
        m_awready = 1'b0; m_wready = 1'b0; m_bid = 4'd1; m_bresp = '0; m_bvalid = 1'b0;

        // Reset values
        #1;
        chk("rst_m_arvalid", 32'(m_arvalid), 32'd0);
        chk("rst_s0_arready", 32'(s0_arready), 32'd0);
        chk("rst_s1_arready", 32'(s1_arready), 32'd0);
        chk("rst_s0_rvalid", 32'(s0_rvalid), 32'd0);
        chk("rst_s1_rvalid", 32'(s1_rvalid), 32'd0);
        chk("rst_m_rready", 32'(m_rready), 32'd0);
        tick();
        tick();
        aresetn = 1'b1;

        // Single icache read, 8 beats
        s0_araddr = 32'h1FC0_0000; s0_arlen = 4'd7; s0_arvalid = 1'b1;
        #1;
        chk("t1_idle_arvalid", 32'(m_arvalid), 32'd0);
        tick();
        chk("t1_araddr", m_araddr, 32'h1FC0_0000);
        chk("t1_arlen", 32'(m_arlen), 32'd7);
        serve(1'b0, 8);
        chk("t1_post_arvalid", 32'(m_arvalid), 32'd0);
        chk("t1_post_s1_rvalid", 32'(s1_rvalid), 32'd0);
        tick();
        chk("t1_idle_hold", 32'(m_arvalid), 32'd0);

        // Simultaneous requests, three rounds
        s0_araddr = 32'h0000_1000; s0_arlen = 4'd0;
        s1_araddr = 32'h8000_2000; s1_arlen = 4'd0;
        for (int r = 0; r < 3; r++) begin
            s0_arvalid = 1'b1;
            s1_arvalid = 1'b1;
            #1;
            chk("t2_idle_arvalid", 32'(m_arvalid), 32'd0);
            tick();
            chk("t2_araddr", m_araddr, exp_gnt[r] ? 32'h8000_2000 : 32'h0000_1000);
            $display("arb round %0d expect gnt=%0d", r, exp_gnt[r]);
            serve(exp_gnt[r], 1);
        end
        s0_arvalid = 1'b0;
        s1_arvalid = 1'b0;
        tick();

        // Read held behind write
        s1_awaddr = 32'h8000_1000; s1_awvalid = 1'b1; m_awready = 1'b1;
        s1_araddr = 32'h8000_1000; s1_arvalid = 1'b1;
        #1;
        chk("t3_m_awvalid", 32'(m_awvalid), 32'd1);
        chk("t3_s1_awready", 32'(s1_awready), 32'd1);
        chk("t3_m_awid", 32'(m_awid), 32'd1);
        chk("t3_m_awaddr", m_awaddr, 32'h8000_1000);
        tick();
        s1_awvalid = 1'b0;
        s1_wdata = 32'hCAFE_F00D; s1_wlast = 1'b1; s1_wvalid = 1'b1; m_wready = 1'b1;
        #1;
        chk("t3_m_wvalid", 32'(m_wvalid), 32'd1);
        chk("t3_m_wid", 32'(m_wid), 32'd1);
        chk("t3_m_wdata", m_wdata, 32'hCAFE_F00D);
        chk("t3_s1_wready", 32'(s1_wready), 32'd1);
        chk("t3_hold_w", 32'(m_arvalid), 32'd0);
        tick();
        s1_wvalid = 1'b0; s1_wlast = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t3_hold", 32'(m_arvalid), 32'd0);
            tick();
        end
        m_bvalid = 1'b1; m_bresp = 2'b00;
        #1;
        chk("t3_s1_bvalid", 32'(s1_bvalid), 32'd1);
        chk("t3_m_bready", 32'(m_bready), 32'd1);
        chk("t3_hold_b", 32'(m_arvalid), 32'd0);
        tick();
        m_bvalid = 1'b0;
        #1;
        chk("t3_eligible_idle", 32'(m_arvalid), 32'd0);
        tick();
        chk("t3_araddr", m_araddr, 32'h8000_1000);
        serve(1'b1, 1);
        tick();

        // wpend saturation
        s1_awaddr = 32'h8000_3000; s1_awvalid = 1'b1; m_awready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4_aw_accept", 32'(s1_awready), 32'd1);
            tick();
        end
        chk("t4_full_awvalid", 32'(m_awvalid), 32'd0);
        chk("t4_full_awready", 32'(s1_awready), 32'd0);
        m_bvalid = 1'b1;
        tick();
        m_bvalid = 1'b0;
        #1;
        chk("t4_reopen_awvalid", 32'(m_awvalid), 32'd1);
        chk("t4_reopen_awready", 32'(s1_awready), 32'd1);
        tick();
        chk("t4_full_again", 32'(m_awvalid), 32'd0);
        m_bvalid = 1'b1;
        tick();
        // wpend=2 here: AW and B together must leave it at 2
        #1;
        chk("t4_both_awready", 32'(s1_awready), 32'd1);
        tick();
        m_bvalid = 1'b0;
        #1;
        chk("t4_after_both", 32'(m_awvalid), 32'd1);
        tick();
        chk("t4_full_third", 32'(m_awvalid), 32'd0);
        s1_awvalid = 1'b0;
        m_bvalid = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        m_bvalid = 1'b0;
        $display("wpend saturation sequence done");

        // Reset mid-burst, with one write left unacknowledged
        s1_awvalid = 1'b1;
        tick();
        s1_awvalid = 1'b0;
        s0_araddr = 32'h1FC0_0040; s0_arlen = 4'd7; s0_arvalid = 1'b1;
        tick();
        chk("t5_ar", 32'(m_arvalid), 32'd1);
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0; s0_arvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_rvalid = 1'b1; m_rdata = 32'h5A00_0000 + 32'(i);
            tick();
        end
        m_rvalid = 1'b1; m_rdata = 32'h5A00_0003;
        #1;
        chk("t5_beat4_rvalid", 32'(s0_rvalid), 32'd1);
        aresetn = 1'b0;
        #1;
        chk("t5_rst_s0_rvalid", 32'(s0_rvalid), 32'd0);
        chk("t5_rst_m_rready", 32'(m_rready), 32'd0);
        chk("t5_rst_m_arvalid", 32'(m_arvalid), 32'd0);
        chk("t5_rst_s0_arready", 32'(s0_arready), 32'd0);
        m_rvalid = 1'b0;
        tick();
        tick();
        aresetn = 1'b1;
        // wpend must be 0 again, so s1 is eligible and wins over s0 in either build
        s0_araddr = 32'h1FC0_0080; s0_arlen = 4'd0; s0_arvalid = 1'b1;
        s1_araddr = 32'h8000_4000; s1_arlen = 4'd0; s1_arvalid = 1'b1;
        #1;
        chk("t5_idle_arvalid", 32'(m_arvalid), 32'd0);
        tick();
        serve(1'b1, 1);
        chk("t5_gap", 32'(m_arvalid), 32'd0);
        tick();
        chk("t5_s0_araddr", m_araddr, 32'h1FC0_0080);
        serve(1'b0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
